// File: rtl/riscv_pkg.sv
// Core-wide constants shared by the RISC-V front-end blocks.
package riscv_pkg;

    localparam int          XLEN       = 32;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam int          INST_BYTES = 4;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage signal bundle: instruction memory request/response, redirect, and decode handoff.
interface inst_fetch_if #(
    parameter int XLEN = 32
);

    // Handshakes: a request or decode transfer completes on a rising edge where valid and
    // ready are both high; valid never waits on ready. Responses carry no ready and are
    // always consumed in the cycle they are presented.
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            id_ready;
    logic            if_valid;
    logic [31:0]     if_inst;
    logic [XLEN-1:0] if_pc;

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_inst, if_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_inst, if_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue of {pc, inst} pairs; flush beats push, and a pushed entry shows up next cycle.
module fetch_fifo #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [XLEN-1:0]              i_pc,
    input  logic [31:0]                  i_inst,
    output logic                         o_valid,
    output logic [XLEN-1:0]              o_pc,
    output logic [31:0]                  o_inst,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  r_pc   [DEPTH];
    logic [31:0]      r_inst [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_do_pop  = i_pop && (r_count != '0);
    // Writing into a full queue is fine when the head leaves in the same cycle.
    assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_do_push && w_do_pop) r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_pc[r_wr_ptr]   <= i_pc;
            r_inst[r_wr_ptr] <= i_inst;
        end
    end

    assign o_valid = (r_count != '0);
    assign o_pc    = r_pc[r_rd_ptr];
    assign o_inst  = r_inst[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the fetch PC, credits memory requests against the prefetch
// queue, and squashes in-flight responses after a redirect.
module inst_fetch
    import riscv_pkg::*;
#(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input logic          clk,
    input logic          rst,
    inst_fetch_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 2;

    logic [XLEN-1:0]  r_fetch_pc;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_drop_cnt;

    logic [CNT_W-1:0] w_count;
    logic             w_fifo_valid;
    logic             w_pop;
    logic             w_issue;
    logic             w_accept;
    logic             w_rsp_live;
    logic             w_rsp_drop;
    logic             w_push;
    logic [SUM_W-1:0] w_credit_used;
    logic [XLEN-1:0]  w_rsp_pc;
    logic [XLEN-1:0]  w_redirect_target;
    logic [XLEN-1:0]  w_head_pc;
    logic [31:0]      w_head_inst;

    assign w_pop = w_fifo_valid && bus.id_ready;

    // Every accepted request, live or stale, holds a queue slot until it returns or is dropped.
    assign w_credit_used = SUM_W'(r_outstanding) + SUM_W'(r_drop_cnt) + SUM_W'(w_count)
                         - SUM_W'(w_pop);
    assign w_issue  = !rst && !bus.redirect_valid && (w_credit_used < SUM_W'(DEPTH));
    assign w_accept = w_issue && bus.imem_req_ready;

    assign w_rsp_drop = bus.imem_rsp_valid && (r_drop_cnt != '0);
    assign w_rsp_live = bus.imem_rsp_valid && (r_drop_cnt == '0);
    assign w_push     = w_rsp_live && !bus.redirect_valid;

    // The oldest live request sits outstanding*4 bytes behind the next fetch address.
    assign w_rsp_pc          = r_fetch_pc - XLEN'(r_outstanding) * XLEN'(INST_BYTES);
    assign w_redirect_target = bus.redirect_pc & ~XLEN'(INST_BYTES - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else if (bus.redirect_valid) begin
            r_fetch_pc    <= w_redirect_target;
            r_drop_cnt    <= r_drop_cnt + r_outstanding - CNT_W'(bus.imem_rsp_valid);
            r_outstanding <= '0;
        end else begin
            if (w_accept)   r_fetch_pc <= r_fetch_pc + XLEN'(INST_BYTES);
            if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - CNT_W'(1);
            if (w_accept && !w_rsp_live)      r_outstanding <= r_outstanding + CNT_W'(1);
            else if (!w_accept && w_rsp_live) r_outstanding <= r_outstanding - CNT_W'(1);
        end
    end

    fetch_fifo #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (bus.redirect_valid),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_pc    (w_rsp_pc),
        .i_inst  (bus.imem_rsp_data),
        .o_valid (w_fifo_valid),
        .o_pc    (w_head_pc),
        .o_inst  (w_head_inst),
        .o_count (w_count)
    );

    assign bus.imem_req_valid = w_issue;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.if_valid       = w_fifo_valid;
    assign bus.if_inst        = w_fifo_valid ? w_head_inst : NOP_INST;
    assign bus.if_pc          = w_fifo_valid ? w_head_pc : '0;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: in-order memory model, expected {pc, inst} queue, decode monitor.
module tb_inst_fetch;
    import riscv_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    inst_fetch_if #(.XLEN(32)) bus ();

    inst_fetch #(
        .XLEN     (32),
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          used_cycles;
    logic [63:0] exp_q [$];
    logic [31:0] pend_q [$];
    logic        rsp_en    = 1'b1;
    logic        mem_fire  = 1'b0;
    logic        mem_taken = 1'b0;
    logic [31:0] mem_addr  = '0;
    logic [63:0] mon_e;
    logic        prev_req_valid = 1'b0;
    logic        prev_req_ready = 1'b0;
    logic [31:0] prev_req_addr  = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, act, req);
        end
    endtask

    task automatic push_stream(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            a = base + 32'(4 * i);
            exp_q.push_back({a, mem_word(a)});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int budget, input bit keep_ready);
        used_cycles = 0;
        while (exp_q.size() > 0 && used_cycles < budget) begin
            step();
            used_cycles++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d entries not seen after %0d cycles", name, exp_q.size(), used_cycles);
            exp_q.delete();
        end
        if (!keep_ready) bus.id_ready = 1'b0;
    endtask

    // In-order memory: a request accepted at an edge is answered in the following cycle
    // unless rsp_en holds the queue back.
    always @(negedge clk) begin
        mem_fire  = bus.imem_req_valid && bus.imem_req_ready;
        mem_addr  = bus.imem_req_addr;
        mem_taken = bus.imem_rsp_valid;
    end

    always @(posedge clk) begin
        #2;
        if (rst) begin
            pend_q.delete();
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end else begin
            if (mem_taken && pend_q.size() > 0) void'(pend_q.pop_front());
            if (mem_fire) pend_q.push_back(mem_addr);
            if (rsp_en && pend_q.size() > 0) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem_word(pend_q[0]);
            end else begin
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = '0;
            end
        end
    end

    // Decode-side monitor plus request-channel rules.
    always @(negedge clk) begin
        if (!rst && !bus.redirect_valid && bus.if_valid && bus.id_ready && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check32("if_pc", bus.if_pc, mon_e[63:32]);
            check32("if_inst", bus.if_inst, mon_e[31:0]);
        end
        if (!rst && prev_req_valid && !prev_req_ready && !bus.redirect_valid) begin
            check32("req_valid_hold", 32'(bus.imem_req_valid), 32'd1);
            check32("req_addr_hold", bus.imem_req_addr, prev_req_addr);
        end
        if (!rst) check32("inflight_bound", (pend_q.size() <= DEPTH) ? 32'd1 : 32'd0, 32'd1);
        prev_req_valid = bus.imem_req_valid && !rst;
        prev_req_ready = bus.imem_req_ready;
        prev_req_addr  = bus.imem_req_addr;
    end

    initial begin
        #100000;
        bad++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.imem_req_ready = 1'b1;
        bus.id_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        repeat (3) step();

        @(negedge clk);
        check32("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check32("rst_if_valid", 32'(bus.if_valid), 32'd0);
        check32("rst_if_inst", bus.if_inst, NOP_INST);
        check32("rst_if_pc", bus.if_pc, 32'd0);

        // Free run from reset: one instruction per cycle after two cycles of latency.
        step();
        push_stream(RESET_PC, 16);
        rst          = 1'b0;
        bus.id_ready = 1'b1;
        @(negedge clk);
        check32("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check32("first_req_addr", bus.imem_req_addr, RESET_PC);
        drain("free_run", 40, 1'b0);
        check32("free_run_cycles", 32'(used_cycles), 32'd18);

        // Decode stall: queue fills and requests stop; nothing lost on resume.
        repeat (10) step();
        @(negedge clk);
        check32("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check32("stall_if_valid", 32'(bus.if_valid), 32'd1);
        check32("stall_if_pc", bus.if_pc, 32'h40);
        step();
        push_stream(32'h40, 16);
        bus.id_ready = 1'b1;
        drain("stall_resume", 40, 1'b0);

        // Two requests in flight when back-to-back redirects land.
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        step();
        bus.redirect_valid = 1'b0;
        repeat (6) step();
        rsp_en             = 1'b0;
        bus.imem_req_ready = 1'b1;
        step();
        step();
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        step();
        bus.redirect_pc    = 32'h103;
        step();
        bus.redirect_valid = 1'b0;
        rsp_en             = 1'b1;
        bus.imem_req_ready = 1'b1;
        push_stream(32'h100, 8);
        bus.id_ready = 1'b1;
        drain("double_redirect", 40, 1'b0);

        // Memory back-pressure: request held steady, then PC advances by one word.
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h300;
        step();
        bus.redirect_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check32("bp_req_valid", 32'(bus.imem_req_valid), 32'd1);
            check32("bp_req_addr", bus.imem_req_addr, 32'h300);
            step();
        end
        bus.imem_req_ready = 1'b1;
        step();
        @(negedge clk);
        check32("bp_next_valid", 32'(bus.imem_req_valid), 32'd1);
        check32("bp_next_addr", bus.imem_req_addr, 32'h304);
        step();
        push_stream(32'h300, 8);
        bus.id_ready = 1'b1;
        drain("backpressure", 40, 1'b0);

        // Redirect in the same cycle as a response and a decode handshake.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h400;
        step();
        bus.redirect_valid = 1'b0;
        push_stream(32'h400, 4);
        bus.id_ready = 1'b1;
        drain("pre_collide", 40, 1'b1);
        @(negedge clk);
        check32("collide_if_valid", 32'(bus.if_valid), 32'd1);
        check32("collide_rsp_valid", 32'(bus.imem_rsp_valid), 32'd1);
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h500;
        step();
        bus.redirect_valid = 1'b0;
        push_stream(32'h500, 6);
        @(negedge clk);
        check32("flush_if_valid", 32'(bus.if_valid), 32'd0);
        check32("flush_if_pc", bus.if_pc, 32'd0);
        check32("flush_if_inst", bus.if_inst, NOP_INST);
        @(negedge clk);
        check32("latency_n2_valid", 32'(bus.if_valid), 32'd0);
        @(negedge clk);
        check32("latency_n3_valid", 32'(bus.if_valid), 32'd1);
        drain("after_collide", 40, 1'b0);

        // Address wrap at the top of the address space.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFF8;
        step();
        bus.redirect_valid = 1'b0;
        push_stream(32'hFFFF_FFF8, 5);
        bus.id_ready = 1'b1;
        drain("wrap", 40, 1'b0);

        // Reset in the middle of streaming.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h600;
        step();
        bus.redirect_valid = 1'b0;
        push_stream(32'h600, 4);
        bus.id_ready = 1'b1;
        drain("pre_reset", 40, 1'b1);
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        check32("midrst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check32("midrst_if_valid", 32'(bus.if_valid), 32'd0);
        check32("midrst_if_pc", bus.if_pc, 32'd0);
        step();
        push_stream(RESET_PC, 8);
        rst = 1'b0;
        @(negedge clk);
        check32("midrst_first_addr", bus.imem_req_addr, RESET_PC);
        drain("after_reset", 40, 1'b0);

        repeat (4) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
